// File: rtl/hazard_scheduler.sv
// Hazard and sequencing controller for the 5-stage RV32 pipeline: EX operand forwarding,
// load-use stalls, branch/jump flushes and the start/done handshake with the multi-cycle MDU.
module hazard_scheduler #(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rs1E,
  input  logic [4:0]       rs2E,
  input  logic [4:0]       rdE,
  input  logic             regwriteE,
  input  logic [1:0]       wbselE,
  input  logic [4:0]       rdM,
  input  logic             regwriteM,
  input  logic [4:0]       rdW,
  input  logic             regwriteW,
  input  logic             pcselE,
  input  logic             mdu_reqE,
  input  logic             mdu_done,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             flushD,
  output logic             flushE,
  output logic             mdu_start,
  output logic             mdu_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int              TMR_W   = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(MDU_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MDU_WAIT = 2'd1,
    MDU_REL  = 2'd2
  } state_t;

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic             lwStall;
  logic             mduStall;

  // MEM-stage producer is younger than WB, so its value takes priority.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if (regwriteM && (rdM != 5'd0) && (rdM == rs1E))      forwardAE = 2'b10;
    else if (regwriteW && (rdW != 5'd0) && (rdW == rs1E)) forwardAE = 2'b01;
    if (regwriteM && (rdM != 5'd0) && (rdM == rs2E))      forwardBE = 2'b10;
    else if (regwriteW && (rdW != 5'd0) && (rdW == rs2E)) forwardBE = 2'b01;
  end

  assign lwStall  = regwriteE && (wbselE == 2'b01) && (rdE != 5'd0) &&
                    ((rdE == rs1D) || (rdE == rs2D));
  assign mduStall = ((state == IDLE) && mdu_reqE) || ((state == MDU_WAIT) && !mdu_done);

  // A taken branch squashes the D instruction, so a load-use stall on it is pointless;
  // an MDU op in EX cannot coexist with a redirect, so the MDU stall overrides flushes.
  assign stallF    = !rst && (mduStall || (lwStall && !pcselE));
  assign stallD    = stallF;
  assign stallE    = !rst && mduStall;
  assign flushD    = !rst && pcselE && !mduStall;
  assign flushE    = !rst && (pcselE || lwStall) && !mduStall;
  assign mdu_start = !rst && (state == IDLE) && mdu_reqE;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      mdu_timeout <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      if (stallF && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);

      case (state)
        IDLE: begin
          if (mdu_reqE) begin
            state <= MDU_WAIT;
            timer <= '0;
          end
        end
        MDU_WAIT: begin
          if (mdu_done) begin
            state <= MDU_REL;
          end else if (timer == TMR_MAX) begin
            mdu_timeout <= 1'b1;
            state       <= MDU_REL;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        // One unstalled cycle lets the finished op leave EX; a held mdu_reqE must not relaunch.
        MDU_REL: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler: each step pushes the expected outputs to a scoreboard
// queue, and the entry is popped and compared against the DUT on the following falling edge.
module tb_hazard_scheduler;

  localparam int TB_TIMEOUT = 8;
  localparam int TB_CNT_W   = 4;

  // Control vector layout: {stallF, stallD, stallE, flushD, flushE, mdu_start, mdu_timeout}
  localparam logic [6:0] NONE  = 7'b0000000;
  localparam logic [6:0] LWS   = 7'b1100100;
  localparam logic [6:0] MDUS  = 7'b1110000;
  localparam logic [6:0] START = 7'b0000010;
  localparam logic [6:0] FLUSH = 7'b0001100;
  localparam logic [6:0] TOUT  = 7'b0000001;

  typedef struct {
    string       tag;
    logic [14:0] want;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst;
  logic [4:0]          rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic                regwriteE, regwriteM, regwriteW, pcselE, mdu_reqE, mdu_done;
  logic [1:0]          wbselE;
  logic [1:0]          forwardAE, forwardBE;
  logic                stallF, stallD, stallE, flushD, flushE, mdu_start, mdu_timeout;
  logic [TB_CNT_W-1:0] stall_cnt;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  hazard_scheduler #(.MDU_TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .regwriteE(regwriteE), .wbselE(wbselE),
    .rdM(rdM), .regwriteM(regwriteM), .rdW(rdW), .regwriteW(regwriteW),
    .pcselE(pcselE), .mdu_reqE(mdu_reqE), .mdu_done(mdu_done),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .flushD(flushD), .flushE(flushE),
    .mdu_start(mdu_start), .mdu_timeout(mdu_timeout), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0;
    rdE = '0; rdM = '0; rdW = '0; wbselE = 2'b00;
    regwriteE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
    pcselE = 1'b0; mdu_reqE = 1'b0; mdu_done = 1'b0;
  endtask

  // Push expectation for the current cycle, compare it mid-cycle, then move to the next cycle.
  task automatic step(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                      input logic [6:0] ctl, input int cnt);
    exp_t e;
    exp_t got;
    logic [14:0] obs;
    e.tag  = tag;
    e.want = {fa, fb, ctl, cnt[TB_CNT_W-1:0]};
    q.push_back(e);
    @(negedge clk);
    got = q.pop_front();
    obs = {forwardAE, forwardBE, stallF, stallD, stallE, flushD, flushE,
           mdu_start, mdu_timeout, stall_cnt};
    total++;
    assert (obs === got.want) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", got.tag, obs, got.want);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;

    // Reset: controls forced low, forwarding still live
    regwriteM = 1'b1; rdM = 5'd3; rs1E = 5'd3; mdu_reqE = 1'b1; pcselE = 1'b1;
    step("reset_outputs", 2'b10, 2'b00, NONE, 0);
    clear_inputs();
    rst = 1'b0;

    // Forwarding priority and enables
    regwriteM = 1'b1; rdM = 5'd5; regwriteW = 1'b1; rdW = 5'd5; rs1E = 5'd5; rs2E = 5'd5;
    step("fwd_mem_prio", 2'b10, 2'b10, NONE, 0);
    rdM = 5'd0;
    step("fwd_wb_rdm0", 2'b01, 2'b01, NONE, 0);
    rs1E = 5'd0; rs2E = 5'd9;
    step("fwd_none", 2'b00, 2'b00, NONE, 0);
    rdM = 5'd6; rs1E = 5'd6; rdW = 5'd7; rs2E = 5'd7;
    step("fwd_mixed", 2'b10, 2'b01, NONE, 0);
    regwriteM = 1'b0; regwriteW = 1'b0;
    step("fwd_no_write", 2'b00, 2'b00, NONE, 0);
    clear_inputs();

    // Load-use
    wbselE = 2'b01; regwriteE = 1'b1; rdE = 5'd7; rs2D = 5'd7;
    step("lw_rs2", 2'b00, 2'b00, LWS, 0);
    pcselE = 1'b1;
    step("lw_with_branch", 2'b00, 2'b00, FLUSH, 1);
    pcselE = 1'b0; rs2D = 5'd0; rs1D = 5'd7;
    step("lw_rs1", 2'b00, 2'b00, LWS, 1);
    wbselE = 2'b10;
    step("non_load", 2'b00, 2'b00, NONE, 2);
    wbselE = 2'b01; rdE = 5'd0; rs1D = 5'd0;
    step("lw_rd0", 2'b00, 2'b00, NONE, 2);
    clear_inputs();
    pcselE = 1'b1;
    step("branch_only", 2'b00, 2'b00, FLUSH, 2);
    clear_inputs();

    rst = 1'b1;
    step("reset_clears_cnt", 2'b00, 2'b00, NONE, 0);
    rst = 1'b0;

    // MDU nominal: done arrives in the fifth WAIT cycle
    mdu_reqE = 1'b1;
    step("mdu_launch", 2'b00, 2'b00, MDUS | START, 0);
    step("mdu_wait1", 2'b00, 2'b00, MDUS, 1);
    pcselE = 1'b1;
    step("mdu_wait2_pcsel", 2'b00, 2'b00, MDUS, 2);
    pcselE = 1'b0;
    step("mdu_wait3", 2'b00, 2'b00, MDUS, 3);
    step("mdu_wait4", 2'b00, 2'b00, MDUS, 4);
    mdu_done = 1'b1;
    step("mdu_done", 2'b00, 2'b00, NONE, 5);
    mdu_done = 1'b0;
    step("mdu_rel_no_relaunch", 2'b00, 2'b00, NONE, 5);
    mdu_reqE = 1'b0; mdu_done = 1'b1;
    step("stray_done_idle", 2'b00, 2'b00, NONE, 5);
    mdu_done = 1'b0;

    // MDU with done in the first WAIT cycle
    mdu_reqE = 1'b1;
    step("mdu_fast_launch", 2'b00, 2'b00, MDUS | START, 5);
    mdu_done = 1'b1;
    step("mdu_fast_done", 2'b00, 2'b00, NONE, 6);
    mdu_done = 1'b0;
    step("mdu_fast_rel", 2'b00, 2'b00, NONE, 6);
    mdu_reqE = 1'b0;
    step("mdu_fast_idle", 2'b00, 2'b00, NONE, 6);

    rst = 1'b1;
    step("reset_before_timeout", 2'b00, 2'b00, NONE, 0);
    rst = 1'b0;

    // Timeout: 1 launch cycle + TB_TIMEOUT waiting cycles of stall
    mdu_reqE = 1'b1;
    step("to_launch", 2'b00, 2'b00, MDUS | START, 0);
    for (int i = 1; i <= TB_TIMEOUT; i++) step("to_wait", 2'b00, 2'b00, MDUS, i);
    step("to_rel", 2'b00, 2'b00, TOUT, 9);
    mdu_reqE = 1'b0; mdu_done = 1'b1;
    step("to_stray_done", 2'b00, 2'b00, TOUT, 9);
    mdu_done = 1'b0; mdu_reqE = 1'b1;
    step("to_sticky_relaunch", 2'b00, 2'b00, MDUS | START | TOUT, 9);
    mdu_done = 1'b1;
    step("to_sticky_done", 2'b00, 2'b00, TOUT, 10);
    mdu_done = 1'b0; mdu_reqE = 1'b0;
    step("to_sticky_idle", 2'b00, 2'b00, TOUT, 10);

    // Reset in the middle of MDU_WAIT
    mdu_reqE = 1'b1;
    step("rm_launch", 2'b00, 2'b00, MDUS | START | TOUT, 10);
    step("rm_wait1", 2'b00, 2'b00, MDUS | TOUT, 11);
    step("rm_wait2", 2'b00, 2'b00, MDUS | TOUT, 12);
    rst = 1'b1;
    step("rm_in_reset", 2'b00, 2'b00, NONE, 0);
    rst = 1'b0;
    step("rm_fresh_launch", 2'b00, 2'b00, MDUS | START, 0);
    mdu_done = 1'b1;
    step("rm_done", 2'b00, 2'b00, NONE, 1);
    mdu_done = 1'b0; mdu_reqE = 1'b0;
    step("rm_rel", 2'b00, 2'b00, NONE, 1);

    rst = 1'b1;
    step("reset_before_sat", 2'b00, 2'b00, NONE, 0);
    rst = 1'b0;

    // Saturation: 20 back-to-back load-use stalls on a 4-bit counter
    wbselE = 2'b01; regwriteE = 1'b1; rdE = 5'd4; rs1D = 5'd4;
    for (int k = 0; k < 20; k++) step("sat_stall", 2'b00, 2'b00, LWS, (k > 15) ? 15 : k);
    clear_inputs();
    step("sat_final", 2'b00, 2'b00, NONE, 15);
    step("sat_hold", 2'b00, 2'b00, NONE, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
